conv_encoder: RTL and testbench
===============================

# conv_encoder

Rate-1/2, constraint-length-3 convolutional encoder, generators (7,5) octal, 4-state trellis. It is the transmit-side counterpart of the pipelined Viterbi ACS/traceback decoder and produces exactly the 2-bit branch labels that the decoder's per-state path_id tables expect. A valid/ready bit stream goes in and a valid/ready codeword stream comes out. Frames are optionally zero-tail terminated so every frame ends in state 00.

## Interface
- FRAME_CNT_W, 16, width of the completed-frame counter.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  in_bit/in_last valid.
- in_ready  output  1  encoder accepts a bit this cycle.
- in_bit  input  1  information bit u.
- in_last  input  1  u is the last information bit of the frame.
- out_valid  output  1  out_code/out_last valid.
- out_ready  input  1  downstream accepts the codeword.
- out_code  output  2  codeword, {u^s1^s0, u^s0}.
- out_last  output  1  codeword is the final one of the frame.
- state_out  output  2  current trellis state {s1,s0}; s1 is the most recent bit.
- frame_cnt  output  FRAME_CNT_W  completed frames, wraps modulo 2^FRAME_CNT_W.

## Operation
- Trellis state: next state = {u, s1}. This matches the decoder convention that the decoded bit equals state[1].
- Branch labels from state {s1,s0}:
  - u=0: 00→00, 01→11, 10→10, 11→01.
  - u=1: 00→11, 01→00, 10→01, 11→10.
- Output slot: one register stage holding out_code/out_last/out_valid. The slot is free when !out_valid || out_ready.
- FSM states: DATA, TAIL1, TAIL2.
- DATA:
  - in_ready = slot free.
  - Accept (in_valid && in_ready): load codeword, update state, set out_valid.
  - If in_last: with the tail feature, go to TAIL1 with out_last=0; without it, out_last=1, frame_cnt+1, stay in DATA.
- TAIL1, when the slot is free: emit the u=0 codeword, update state, go to TAIL2. in_ready=0.
- TAIL2, when the slot is free: emit the u=0 codeword with out_last=1, update state (always 00 here), increment frame_cnt, go to DATA. in_ready=0.
- in_valid is ignored whenever in_ready=0; no bit is consumed and no state changes.
- out_valid falls only when out_ready=1 and no new codeword loads in the same cycle.
- Reset (any time, including mid-tail):
  - out_valid=0, out_code=00, out_last=0.
  - state_out=00, frame_cnt=0, FSM=DATA.
  - Any pending codeword is discarded.

## Timing
- Latency: a bit accepted at edge N appears on out_code after edge N. Throughput is one codeword per cycle.
- in_ready depends combinationally on out_ready. No other combinational input-to-output path exists.
- out_code and out_last hold stable while out_valid=1 and out_ready=0.
- Tail overhead: in_last accepted at edge N gives TAIL1 at N+1 and TAIL2 at N+2 under continuous out_ready. in_ready returns high in the cycle after TAIL2 is emitted.
- frame_cnt updates on the edge that loads the out_last=1 codeword.

## Configuration
- CONV_ENCODER_TAIL_EN defined:
  - Two zero tail bits are appended after in_last, so each frame of L bits yields L+2 codewords.
  - The trellis ends in 00, so the decoder starts each frame from state 00.
- CONV_ENCODER_TAIL_EN undefined:
  - TAIL1 and TAIL2 are not built; each frame yields L codewords.
  - out_last is flagged on the codeword of the in_last bit.
  - Trellis state carries across frame boundaries (continuous stream).

## Structure
- Shared package viterbi_pkg:
  - K=3, NUM_STATES=4.
  - G_HI=3'b111, G_LO=3'b101.
  - 2-bit state and codeword typedefs.
  - encoder FSM enum.
  - Decoder and encoder both use these.
- Sub-module conv_branch: combinational ({s1,s0}, u) → (code[1:0], next_state[1:0]).
  - Reused by a decoder-side reference model in the bench.

## Test plan
- Frame 1,0,1,1 (last on 4th) from reset, out_ready=1, tail on → out_code 11,10,00,01,01,11; out_last only on the 6th; state_out=00; frame_cnt=1.
- Same frame with tail off → out_code 11,10,00,01 with out_last on the 4th; state_out=11. A following bit 0 then yields 01.
- Backpressure: out_ready=0 for 3 cycles with a codeword pending → out_code stable, in_ready=0, no bit lost; sequence identical to the unstalled run.
- Assert in_valid=1 with garbage bits during TAIL1/TAIL2 → bits ignored, in_ready=0, tail codewords unchanged.
- Assert rst while in TAIL2 → next cycle out_valid=0, state_out=00, frame_cnt=0; a new frame 1 (last) encodes as 11 then tail 10,11.
- Run 2^FRAME_CNT_W+1 single-bit frames (FRAME_CNT_W=4) → frame_cnt wraps 15→0→1.

Source files
------------

// File: rtl/viterbi_pkg.sv
// viterbi_pkg: trellis constants and types shared by the (7,5) convolutional encoder and Viterbi decoder.
package viterbi_pkg;
   localparam int K = 3;
   localparam int NUM_STATES = 4;
   localparam logic [2:0] G_HI = 3'b111;
   localparam logic [2:0] G_LO = 3'b101;
   typedef logic [1:0] state_t;
   typedef logic [1:0] code_t;
   typedef enum logic [1:0] {DATA, TAIL1, TAIL2} enc_state_e;
endpackage

// File: rtl/conv_branch.sv
// conv_branch: one trellis branch, ({s1,s0}, u) -> codeword and next state {u,s1}.
module conv_branch
   import viterbi_pkg::*;
(
   input  state_t state,
   input  logic   u,
   output code_t  code,
   output state_t next_state
);
   logic [2:0] reg_bits;
   assign reg_bits = {u, state};
   assign code = {^(reg_bits & G_HI), ^(reg_bits & G_LO)};
   assign next_state = {u, state[1]};
endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 K=3 (7,5) encoder with a one-deep output slot.
// Define CONV_ENCODER_TAIL_EN to append two zero tail bits per frame.
module conv_encoder
   import viterbi_pkg::*;
#(
   parameter int FRAME_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_bit,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output code_t                  out_code,
   output logic                   out_last,
   output state_t                 state_out,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);
   enc_state_e fsm, fsm_nxt;
   logic slot_free, load, last, u;
   code_t code;
   state_t next_state;

   assign slot_free = !out_valid || out_ready;

   conv_branch branch (.state(state_out), .u(u), .code(code), .next_state(next_state));

   always_comb begin
      fsm_nxt = fsm;
      u = 1'b0;
      load = 1'b0;
      last = 1'b0;
      in_ready = 1'b0;
      case (fsm)
         DATA: begin
            in_ready = slot_free;
            load = in_valid && slot_free;
            u = in_bit;
`ifdef CONV_ENCODER_TAIL_EN
            if (load && in_last) fsm_nxt = TAIL1;
`else
            last = in_last;
`endif
         end
`ifdef CONV_ENCODER_TAIL_EN
         TAIL1: begin
            load = slot_free;
            if (load) fsm_nxt = TAIL2;
         end
         TAIL2: begin
            load = slot_free;
            last = 1'b1;
            if (load) fsm_nxt = DATA;
         end
`endif
         default: fsm_nxt = DATA;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm <= DATA;
         state_out <= '0;
         out_code <= '0;
         out_last <= 1'b0;
         out_valid <= 1'b0;
         frame_cnt <= '0;
      end else begin
         fsm <= fsm_nxt;
         if (load) begin
            state_out <= next_state;
            out_code <= code;
            out_last <= last;
            out_valid <= 1'b1;
            if (last) frame_cnt <= frame_cnt + 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: directed checks of the (7,5) encoder; expectations follow CONV_ENCODER_TAIL_EN.
module tb_conv_encoder;
   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, in_bit = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid, out_last;
   logic [1:0] out_code, state_out;
   logic [3:0] frame_cnt;
   int checks = 0, errors = 0;
   logic [2:0] q[$];

   conv_encoder #(.FRAME_CNT_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
      .out_last(out_last), .state_out(state_out), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // Record each codeword transfer ({last,code}) ahead of the edge that completes it.
   always @(negedge clk) if (!rst && out_valid && out_ready) q.push_back({out_last, out_code});

`ifdef CONV_ENCODER_TAIL_EN
   localparam int FRAME_N = 6;
   localparam int PER_FRAME = 3;
   localparam logic [2:0] FRAME_EXP [6] = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
`else
   localparam int FRAME_N = 4;
   localparam int PER_FRAME = 1;
   localparam logic [2:0] FRAME_EXP [6] = '{3'b011, 3'b010, 3'b000, 3'b101, 3'b000, 3'b000};
`endif

   task automatic push_bit(input logic b, input logic l);
      bit ok = 0;
      in_valid = 1'b1; in_bit = b; in_last = l;
      for (int t = 0; t < 20 && !ok; t++) begin
         @(negedge clk);
         ok = in_ready;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL push_timeout in_ready=%b required 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_out(input int n);
      bit ok = 0;
      for (int t = 0; t < 40 && !ok; t++) begin
         @(posedge clk); #2;
         ok = q.size() >= n;
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL out_timeout got %0d codewords required %0d", q.size(), n); end
   endtask

   task automatic do_reset();
      rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
   endtask

   task automatic check_frame_seq(input string name);
      for (int i = 0; i < FRAME_N; i++) begin
         checks++;
         if (i >= q.size() || q[i] !== FRAME_EXP[i]) begin
            errors++;
            $display("FAIL %s cw%0d got %b required %b", name, i, (i < q.size()) ? q[i] : 3'bxxx, FRAME_EXP[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b required 0", out_valid); end
      checks++; if (out_code !== 2'b00) begin errors++; $display("FAIL rst_code got %b required 00", out_code); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b required 0", out_last); end
      checks++; if (state_out !== 2'b00) begin errors++; $display("FAIL rst_state got %b required 00", state_out); end
      checks++; if (frame_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got %0d required 0", frame_cnt); end
      do_reset();
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b required 1", in_ready); end
   endtask

   task automatic test_frame();
      do_reset();
      push_bit(1, 0); push_bit(0, 0); push_bit(1, 0); push_bit(1, 1);
      wait_out(FRAME_N);
      check_frame_seq("frame");
      checks++; if (frame_cnt !== 4'd1) begin errors++; $display("FAIL frame_cnt got %0d required 1", frame_cnt); end
`ifdef CONV_ENCODER_TAIL_EN
      checks++; if (state_out !== 2'b00) begin errors++; $display("FAIL frame_state got %b required 00", state_out); end
`else
      checks++; if (state_out !== 2'b11) begin errors++; $display("FAIL frame_state got %b required 11", state_out); end
      push_bit(0, 0);
      wait_out(5);
      checks++; if (q.size() < 5 || q[4] !== 3'b001) begin errors++; $display("FAIL cont_code got %b required 001", (q.size() >= 5) ? q[4] : 3'bxxx); end
      checks++; if (state_out !== 2'b01) begin errors++; $display("FAIL cont_state got %b required 01", state_out); end
`endif
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      push_bit(1, 0);
      in_valid = 1'b1; in_bit = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1 || out_code !== 2'b11) begin errors++; $display("FAIL bp_hold%0d got v=%b code=%b required v=1 code=11", c, out_valid, out_code); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %b required 0", c, in_ready); end
         checks++; if (state_out !== 2'b10) begin errors++; $display("FAIL bp_state%0d got %b required 10", c, state_out); end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      push_bit(0, 0); push_bit(1, 0); push_bit(1, 1);
      wait_out(FRAME_N);
      check_frame_seq("bp");
   endtask

   task automatic test_tail_garbage();
`ifdef CONV_ENCODER_TAIL_EN
      do_reset();
      push_bit(1, 1);
      in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL tail_ready%0d got %b required 0", c, in_ready); end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
      wait_out(3);
      checks++; if (q.size() != 3 || q[0] !== 3'b011 || q[1] !== 3'b010 || q[2] !== 3'b111) begin
         errors++; $display("FAIL tail_seq got n=%0d %b %b %b required 011 010 111", q.size(), q.size() > 0 ? q[0] : 3'bx, q.size() > 1 ? q[1] : 3'bx, q.size() > 2 ? q[2] : 3'bx);
      end
      checks++; if (state_out !== 2'b00) begin errors++; $display("FAIL tail_state got %b required 00", state_out); end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
`ifdef CONV_ENCODER_TAIL_EN
      push_bit(1, 1);
      @(posedge clk); #1;
`else
      push_bit(1, 0);
`endif
      rst = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b required 0", out_valid); end
      checks++; if (state_out !== 2'b00) begin errors++; $display("FAIL mid_state got %b required 00", state_out); end
      checks++; if (frame_cnt !== 4'd0) begin errors++; $display("FAIL mid_cnt got %0d required 0", frame_cnt); end
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      push_bit(1, 1);
      wait_out(PER_FRAME);
      checks++; if (q.size() < 1 || q[0] !== {PER_FRAME == 1, 2'b11}) begin errors++; $display("FAIL mid_first got %b required %b", q.size() > 0 ? q[0] : 3'bx, {PER_FRAME == 1, 2'b11}); end
`ifdef CONV_ENCODER_TAIL_EN
      checks++; if (q.size() != 3 || q[1] !== 3'b010 || q[2] !== 3'b111) begin errors++; $display("FAIL mid_tail got n=%0d required 010 111", q.size()); end
`endif
   endtask

   task automatic test_wrap();
      do_reset();
      for (int f = 1; f <= 17; f++) begin
         push_bit(0, 1);
         wait_out(f * PER_FRAME);
         if (f >= 15) begin
            checks++;
            if (frame_cnt !== 4'(f)) begin errors++; $display("FAIL wrap_cnt%0d got %0d required %0d", f, frame_cnt, 4'(f)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_backpressure();
      test_tail_garbage();
      test_reset_mid();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
